alu_serial: RTL and testbench

Bit-serial execute unit at the far end of the serial register-file operand interface. It consumes the two operand bit streams (rs1, rs2) LSB-first, one bit per clock. It drives the register file's shift/write strobes and returns the result LSB-first on the write-bit line. A `start`/`done` handshake with the instruction sequencer brackets each operation, and zero/carry flags are exported to branch logic.

---
 rtl/alu_serial.sv | 144 ++++++++++++++
 tb/tb_alu_serial.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial.sv
// alu_serial: bit-serial execute unit; consumes rs1/rs2 LSB-first and drives the
// serial register-file strobes. SLT spends a second pass writing its 0/1 result.
module alu_serial #(
  parameter int REG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [2:0]           opcode,
  input  logic                 use_imm,
  input  logic [REG_WIDTH-1:0] imm,
  input  logic                 rs1_bit,
  input  logic                 rs2_bit,
  output logic                 reg_shift_en,
  output logic                 wr_en,
  output logic                 wr_bit,
  output logic                 busy,
  output logic                 done,
  output logic                 flag_zero,
  output logic                 flag_carry
);
  localparam int CNT_W = (REG_WIDTH > 1) ? $clog2(REG_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REG_WIDTH - 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_CMP  = 3'b110;
  localparam logic [2:0] OP_MOVI = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_PASS1, S_PASS2, S_DONE} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic                 carry, sticky;
  logic [2:0]           op_q;
  logic                 use_imm_q;
  logic [REG_WIDTH-1:0] imm_sr;
  logic                 a_msb, binv_msb, r_msb;

  logic sub_like, arith, is_write, b_eff, r, carry_nxt, last, lt;

  always_comb begin
    sub_like  = (op_q == OP_SUB) || (op_q == OP_CMP) || (op_q == OP_SLT);
    arith     = sub_like || (op_q == OP_ADD);
    is_write  = !((op_q == OP_CMP) || (op_q == OP_SLT));
    b_eff     = (use_imm_q ? imm_sr[0] : rs2_bit) ^ sub_like;
    carry_nxt = (rs1_bit & b_eff) | (rs1_bit & carry) | (b_eff & carry);
    case (op_q)
      OP_AND:  r = rs1_bit & b_eff;
      OP_OR:   r = rs1_bit | b_eff;
      OP_XOR:  r = rs1_bit ^ b_eff;
      OP_MOVI: r = imm_sr[0];
      default: r = rs1_bit ^ b_eff ^ carry;
    endcase
    last = (cnt == CNT_LAST);
    // Signed less-than from the subtraction MSBs: N xor overflow.
    lt   = r_msb ^ ((a_msb ~^ binv_msb) & (a_msb ^ r_msb));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    reg_shift_en = 1'b0;
    wr_en        = 1'b0;
    wr_bit       = 1'b0;
    done         = 1'b0;
    busy         = (state != S_IDLE);
    case (state)
      S_IDLE: if (start) state_nxt = S_PASS1;
      S_PASS1: begin
        if (is_write) begin
          wr_en  = 1'b1;
          wr_bit = r;
        end else begin
          reg_shift_en = 1'b1;
        end
        if (last) state_nxt = (op_q == OP_SLT) ? S_PASS2 : S_DONE;
      end
      S_PASS2: begin
        wr_en  = 1'b1;
        wr_bit = (cnt == '0) ? lt : 1'b0;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt        <= '0;
      carry      <= 1'b0;
      sticky     <= 1'b0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          cnt    <= '0;
          sticky <= 1'b0;
          carry  <= (opcode == OP_SUB) || (opcode == OP_CMP) || (opcode == OP_SLT);
        end
        S_PASS1: begin
          cnt    <= last ? '0 : cnt + 1'b1;
          sticky <= sticky | r;
          if (arith) carry <= carry_nxt;
          if (last) begin
            flag_zero  <= ~(sticky | r);
            flag_carry <= arith ? carry_nxt : carry;
          end
        end
        S_PASS2: cnt <= last ? '0 : cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Operand latches and MSB captures carry no reset: only the FSM gates their use.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      op_q      <= opcode;
      use_imm_q <= use_imm;
      imm_sr    <= imm;
    end else if (state == S_PASS1) begin
      imm_sr <= imm_sr >> 1;
      if (last) begin
        a_msb    <= rs1_bit;
        binv_msb <= b_eff;
        r_msb    <= r;
      end
    end
  end
endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial: serial register-file model plus arithmetic reference model.
module tb_alu_serial;
  localparam int W = 8;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4, OP_SLT = 3'd5, OP_CMP = 3'd6, OP_MOVI = 3'd7;

  logic         clk = 1'b0;
  logic         rstn = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   opcode = '0;
  logic         use_imm = 1'b0;
  logic [W-1:0] imm = '0;
  logic         rs1_bit, rs2_bit;
  logic         reg_shift_en, wr_en, wr_bit, busy, done, flag_zero, flag_carry;

  logic [W-1:0] rs1_reg = '0;
  logic [W-1:0] rs2_reg = '0;
  logic [2:0]   idx;
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;

  alu_serial #(.REG_WIDTH(W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .opcode(opcode), .use_imm(use_imm),
    .imm(imm), .rs1_bit(rs1_bit), .rs2_bit(rs2_bit), .reg_shift_en(reg_shift_en),
    .wr_en(wr_en), .wr_bit(wr_bit), .busy(busy), .done(done),
    .flag_zero(flag_zero), .flag_carry(flag_carry)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register-file bit index: advances on either strobe, resets with rstn.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) idx <= '0;
    else if (wr_en || reg_shift_en) idx <= idx + 3'd1;
  end
  assign rs1_bit = rs1_reg[idx];
  assign rs2_bit = rs2_reg[idx];

  typedef struct {
    logic [W-1:0] wres;
    bit zero; bit carry;
    int nwr; int nsh; int dcyc;
  } exp_t;

  typedef struct {
    logic [W-1:0] res;
    int nwr; int nsh; int dcyc; int dabs;
    bit overlap; bit timeout; bit busy_pre; bit done_pre; bit busy_c1; bit busy_done;
  } obs_t;

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, b, im);
    exp_t e;
    logic [W:0] sum;
    logic [W-1:0] fres;
    e.nwr = W; e.nsh = 0; e.dcyc = W + 1; e.carry = 1'b0;
    case (op)
      OP_ADD: begin sum = {1'b0, a} + {1'b0, b}; e.wres = sum[W-1:0]; e.carry = sum[W]; end
      OP_SUB: begin e.wres = a - b; e.carry = (a >= b); end
      OP_AND: e.wres = a & b;
      OP_OR:  e.wres = a | b;
      OP_XOR: e.wres = a ^ b;
      OP_MOVI: e.wres = im;
      OP_CMP: begin e.wres = '0; e.carry = (a >= b); e.nwr = 0; e.nsh = W; end
      default: begin
        e.wres = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
        e.carry = (a >= b); e.nsh = W; e.dcyc = 2 * W + 1;
      end
    endcase
    fres = (op == OP_CMP || op == OP_SLT) ? (a - b) : e.wres;
    e.zero = (fres == '0);
    return e;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, b, im,
                        input logic ui, input bit hold, output obs_t o);
    int k;
    o.res = '0; o.nwr = 0; o.nsh = 0; o.dcyc = 0; o.dabs = 0;
    o.overlap = 0; o.timeout = 1; o.busy_done = 0;
    @(negedge clk);
    o.busy_pre = busy; o.done_pre = done;
    rs1_reg = a; rs2_reg = b; opcode = op; imm = im; use_imm = ui; start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    o.busy_c1 = busy;
    k = 1;
    while (k <= 4 * W + 8) begin
      if (wr_en) begin
        if (o.nwr < W) o.res[o.nwr] = wr_bit;
        o.nwr++;
      end
      if (reg_shift_en) o.nsh++;
      if (wr_en && reg_shift_en) o.overlap = 1;
      if (done) begin
        o.dcyc = k; o.dabs = cyc; o.busy_done = busy; o.timeout = 0;
        break;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    #2 rstn = 1'b0;
    @(negedge clk);
    checks++;
    if ({reg_shift_en, wr_en, wr_bit, busy, done, flag_zero, flag_carry} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0000000",
               {reg_shift_en, wr_en, wr_bit, busy, done, flag_zero, flag_carry});
    end
    rstn = 1'b1;
    run_op(OP_ADD, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, o);
    checks++;
    if (o.busy_pre !== 1'b0 || o.busy_c1 !== 1'b1) begin
      failures++;
      $display("FAIL reset_busy_rise got=%b%b exp=01", o.busy_pre, o.busy_c1);
    end
    checks++;
    if (o.timeout || o.res !== 8'h46) begin
      failures++;
      $display("FAIL reset_first_add got=%h timeout=%0d exp=46", o.res, o.timeout);
    end
  endtask

  task automatic test_add();
    obs_t o;
    run_op(OP_ADD, 8'h7F, 8'h01, 8'h00, 1'b0, 1'b0, o);
    checks++;
    if (o.res !== 8'h80) begin failures++; $display("FAIL add_result got=%h exp=80", o.res); end
    checks++;
    if (o.nwr !== 8 || o.nsh !== 0 || o.dcyc !== 9) begin
      failures++;
      $display("FAIL add_timing got=wr%0d sh%0d done@%0d exp=wr8 sh0 done@9", o.nwr, o.nsh, o.dcyc);
    end
    checks++;
    if (flag_carry !== 1'b0 || flag_zero !== 1'b0) begin
      failures++;
      $display("FAIL add_flags got=c%b z%b exp=c0 z0", flag_carry, flag_zero);
    end
  endtask

  task automatic test_sub_imm();
    obs_t o;
    run_op(OP_SUB, 8'h05, 8'hC3, 8'h05, 1'b1, 1'b0, o);
    checks++;
    if (o.res !== 8'h00 || o.nwr !== 8) begin
      failures++;
      $display("FAIL sub_imm_result got=%h wr%0d exp=00 wr8", o.res, o.nwr);
    end
    checks++;
    if (flag_zero !== 1'b1 || flag_carry !== 1'b1) begin
      failures++;
      $display("FAIL sub_imm_flags got=z%b c%b exp=z1 c1", flag_zero, flag_carry);
    end
  endtask

  task automatic test_slt();
    obs_t o;
    run_op(OP_SLT, 8'hFE, 8'h03, 8'h00, 1'b0, 1'b0, o);
    checks++;
    if (o.res !== 8'h01 || o.nsh !== 8 || o.nwr !== 8 || o.dcyc !== 17) begin
      failures++;
      $display("FAIL slt_lt got=%h sh%0d wr%0d done@%0d exp=01 sh8 wr8 done@17",
               o.res, o.nsh, o.nwr, o.dcyc);
    end
    run_op(OP_SLT, 8'h03, 8'hFE, 8'h00, 1'b0, 1'b0, o);
    checks++;
    if (o.res !== 8'h00 || o.nwr !== 8) begin
      failures++;
      $display("FAIL slt_swapped got=%h wr%0d exp=00 wr8", o.res, o.nwr);
    end
  endtask

  task automatic test_cmp();
    obs_t o;
    run_op(OP_CMP, 8'h10, 8'h20, 8'h00, 1'b0, 1'b0, o);
    checks++;
    if (o.nwr !== 0 || o.nsh !== 8 || idx !== 3'd0) begin
      failures++;
      $display("FAIL cmp_strobes got=wr%0d sh%0d idx%0d exp=wr0 sh8 idx0", o.nwr, o.nsh, idx);
    end
    checks++;
    if (flag_carry !== 1'b0 || flag_zero !== 1'b0) begin
      failures++;
      $display("FAIL cmp_flags got=c%b z%b exp=c0 z0", flag_carry, flag_zero);
    end
  endtask

  task automatic test_start_held();
    obs_t o;
    int act;
    run_op(OP_ADD, 8'h21, 8'h12, 8'h00, 1'b0, 1'b1, o);
    checks++;
    if (o.nwr !== 8 || o.dcyc !== 9 || o.res !== 8'h33) begin
      failures++;
      $display("FAIL held_start_op got=%h wr%0d done@%0d exp=33 wr8 done@9", o.res, o.nwr, o.dcyc);
    end
    act = 0;
    repeat (2 * W) begin
      @(negedge clk);
      act += int'(busy | wr_en | reg_shift_en | done);
    end
    checks++;
    if (act !== 0) begin failures++; $display("FAIL held_start_retrigger got=%0d exp=0", act); end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    run_op(OP_XOR, 8'hA5, 8'h0F, 8'h00, 1'b0, 1'b0, o1);
    run_op(OP_OR, 8'h50, 8'h00, 8'h0A, 1'b1, 1'b0, o2);
    checks++;
    if (o2.dabs - o1.dabs !== W + 2) begin
      failures++;
      $display("FAIL b2b_throughput got=%0d exp=%0d", o2.dabs - o1.dabs, W + 2);
    end
    checks++;
    if (o2.done_pre !== 1'b0 || o2.busy_pre !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done_pulse got=done%b busy%b exp=done0 busy0", o2.done_pre, o2.busy_pre);
    end
    checks++;
    if (o1.res !== 8'hAA || o2.res !== 8'h5A) begin
      failures++;
      $display("FAIL b2b_results got=%h,%h exp=aa,5a", o1.res, o2.res);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int act;
    run_op(OP_SUB, 8'h05, 8'h00, 8'h05, 1'b1, 1'b0, o);
    @(negedge clk);
    rs1_reg = 8'h0F; rs2_reg = 8'h01; opcode = OP_ADD; use_imm = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_en !== 1'b1) begin failures++; $display("FAIL midrst_active got=%b exp=1", wr_en); end
    rstn = 1'b0;
    #1;
    checks++;
    if ({reg_shift_en, wr_en, wr_bit, busy, done, flag_zero, flag_carry, idx} !== 10'b0) begin
      failures++;
      $display("FAIL midrst_clear got=%b exp=0",
               {reg_shift_en, wr_en, wr_bit, busy, done, flag_zero, flag_carry, idx});
    end
    @(negedge clk);
    rstn = 1'b1;
    act = 0;
    repeat (2 * W) begin
      @(negedge clk);
      act += int'(busy | wr_en | reg_shift_en | done);
    end
    checks++;
    if (act !== 0) begin failures++; $display("FAIL midrst_quiet got=%0d exp=0", act); end
    run_op(OP_ADD, 8'h03, 8'h04, 8'h00, 1'b0, 1'b0, o);
    checks++;
    if (o.res !== 8'h07 || o.nwr !== 8 || o.timeout) begin
      failures++;
      $display("FAIL midrst_next_add got=%h wr%0d exp=07 wr8", o.res, o.nwr);
    end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic [2:0] op;
    logic [W-1:0] a, b, im;
    logic ui;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = 8'($urandom);
      im = 8'($urandom);
      ui = 1'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        if (ui) im = a;
        else    b  = a;
      end
      run_op(op, a, b, im, ui, 1'b0, o);
      e = model(op, a, ui ? im : b, im);
      checks++;
      if (o.timeout || o.dcyc !== e.dcyc || !o.busy_done) begin
        failures++;
        $display("FAIL rand%0d_done op=%0d got=done@%0d exp=done@%0d", i, op, o.dcyc, e.dcyc);
      end
      checks++;
      if (o.nwr !== e.nwr || o.nsh !== e.nsh || o.overlap || idx !== 3'd0) begin
        failures++;
        $display("FAIL rand%0d_strobes op=%0d got=wr%0d sh%0d ov%0d idx%0d exp=wr%0d sh%0d ov0 idx0",
                 i, op, o.nwr, o.nsh, o.overlap, idx, e.nwr, e.nsh);
      end
      if (e.nwr != 0) begin
        checks++;
        if (o.res !== e.wres) begin
          failures++;
          $display("FAIL rand%0d_result op=%0d a=%h b=%h imm=%h ui=%b got=%h exp=%h",
                   i, op, a, b, im, ui, o.res, e.wres);
        end
      end
      checks++;
      if (flag_zero !== e.zero || flag_carry !== e.carry) begin
        failures++;
        $display("FAIL rand%0d_flags op=%0d a=%h b=%h got=z%b c%b exp=z%b c%b",
                 i, op, a, b, flag_zero, flag_carry, e.zero, e.carry);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_add();
    test_sub_imm();
    test_slt();
    test_cmp();
    test_start_held();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
